// File: rtl/hs_deserializer.sv
// HS receive deserializer: takes two serial bits per DDR clock, hunts for the
// sync byte at either bit phase, then emits LSB-first bytes every 4 cycles.
module hs_deserializer #(
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter int         HUNT_TIMEOUT = 64,
  parameter bit         SOT_TOLERANT = 1'b1
) (
  input  logic       RxDDRClkHS,
  input  logic       RxRst,
  input  logic       Deserializer_Enable,
  input  logic       Serial_Bit1,
  input  logic       Serial_Bit2,
  output logic [7:0] RxByteHS_Data,
  output logic       RxValidHS,
  output logic       RxActiveHS,
  output logic       RxSyncHS,
  output logic       ErrSotHS,
  output logic       ErrSotSyncHS
);

  localparam int HCW = $clog2(HUNT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t         r_state;
  logic [9:0]     r_hist;
  logic           r_phase;
  logic [1:0]     r_cnt;
  logic [HCW-1:0] r_hunt_cnt;
  logic [7:0]     r_byte;
  logic           r_valid;
  logic           r_active;
  logic           r_sync;
  logic           r_err_sot;
  logic           r_err_sync;

  logic [7:0]     w_win [2];
  logic [1:0]     w_exact;
  logic [1:0]     w_tol;
  logic           w_match;
  logic           w_match_phase;
  logic           w_match_tol;
  logic [HCW-1:0] w_hunt_cnt_inc;

  // Window gi ends on the newest bit minus gi; the bit just below it must be 0
  // for a tolerant match so a shifted sync cannot pass as a one-bit error.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_win
      logic [7:0] w_diff;
      assign w_win[gi]   = r_hist[9-gi -: 8];
      assign w_diff      = w_win[gi] ^ SYNC_WORD;
      assign w_exact[gi] = (w_diff == 8'd0);
      assign w_tol[gi]   = SOT_TOLERANT && (w_diff != 8'd0) &&
                           ((w_diff & (w_diff - 8'd1)) == 8'd0) &&
                           !r_hist[1-gi];
    end
  endgenerate

  always_comb begin
    w_match       = 1'b0;
    w_match_phase = 1'b0;
    w_match_tol   = 1'b0;
    if (w_exact[0]) begin
      w_match = 1'b1;
    end else if (w_exact[1]) begin
      w_match       = 1'b1;
      w_match_phase = 1'b1;
    end else if (w_tol[0]) begin
      w_match     = 1'b1;
      w_match_tol = 1'b1;
    end else if (w_tol[1]) begin
      w_match       = 1'b1;
      w_match_phase = 1'b1;
      w_match_tol   = 1'b1;
    end
  end

  assign w_hunt_cnt_inc = (r_hunt_cnt == HCW'(HUNT_TIMEOUT)) ? r_hunt_cnt
                                                             : r_hunt_cnt + 1'b1;

  always_ff @(posedge RxDDRClkHS) begin
    if (RxRst) begin
      r_state    <= ST_IDLE;
      r_hist     <= '0;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_hunt_cnt <= '0;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
      r_sync     <= 1'b0;
      r_err_sot  <= 1'b0;
      r_err_sync <= 1'b0;
    end else if (!Deserializer_Enable) begin
      // Lane left HS: drop any partial byte; the last good byte stays visible.
      r_state    <= ST_IDLE;
      r_hist     <= '0;
      r_cnt      <= '0;
      r_hunt_cnt <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
      r_sync     <= 1'b0;
      r_err_sot  <= 1'b0;
      r_err_sync <= 1'b0;
    end else begin
      r_hist    <= {Serial_Bit2, Serial_Bit1, r_hist[9:2]};
      r_valid   <= 1'b0;
      r_sync    <= 1'b0;
      r_err_sot <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_HUNT;
        end
        ST_HUNT: begin
          r_hunt_cnt <= w_hunt_cnt_inc;
          if (w_hunt_cnt_inc == HCW'(HUNT_TIMEOUT)) begin
            r_err_sync <= 1'b1;
          end
          if (w_match) begin
            r_phase   <= w_match_phase;
            r_cnt     <= '0;
            r_state   <= ST_DATA;
            r_active  <= 1'b1;
            r_sync    <= 1'b1;
            r_err_sot <= w_match_tol;
          end
        end
        ST_DATA: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_byte  <= r_phase ? w_win[1] : w_win[0];
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign RxByteHS_Data = r_byte;
  assign RxValidHS     = r_valid;
  assign RxActiveHS    = r_active;
  assign RxSyncHS      = r_sync;
  assign ErrSotHS      = r_err_sot;
  assign ErrSotSyncHS  = r_err_sync;

endmodule

// File: tb/tb_hs_deserializer.sv
// Directed bench: a tolerant and a strict deserializer share one serial stream.
module tb_hs_deserializer;

  logic       RxDDRClkHS = 1'b0;
  logic       RxRst = 1'b1;
  logic       Deserializer_Enable = 1'b0;
  logic       Serial_Bit1 = 1'b0;
  logic       Serial_Bit2 = 1'b0;

  logic [7:0] t_data, s_data;
  logic       t_valid, t_active, t_sync, t_errsot, t_errsync;
  logic       s_valid, s_active, s_sync, s_errsot, s_errsync;

  int errors = 0;
  int checks = 0;

  always #5 RxDDRClkHS = ~RxDDRClkHS;

  hs_deserializer #(.SYNC_WORD(8'hB8), .HUNT_TIMEOUT(64), .SOT_TOLERANT(1'b1)) dut_t (
    .RxDDRClkHS(RxDDRClkHS), .RxRst(RxRst), .Deserializer_Enable(Deserializer_Enable),
    .Serial_Bit1(Serial_Bit1), .Serial_Bit2(Serial_Bit2),
    .RxByteHS_Data(t_data), .RxValidHS(t_valid), .RxActiveHS(t_active),
    .RxSyncHS(t_sync), .ErrSotHS(t_errsot), .ErrSotSyncHS(t_errsync));

  hs_deserializer #(.SYNC_WORD(8'hB8), .HUNT_TIMEOUT(64), .SOT_TOLERANT(1'b0)) dut_s (
    .RxDDRClkHS(RxDDRClkHS), .RxRst(RxRst), .Deserializer_Enable(Deserializer_Enable),
    .Serial_Bit1(Serial_Bit1), .Serial_Bit2(Serial_Bit2),
    .RxByteHS_Data(s_data), .RxValidHS(s_valid), .RxActiveHS(s_active),
    .RxSyncHS(s_sync), .ErrSotHS(s_errsot), .ErrSotSyncHS(s_errsync));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One DDR edge with the given bit pair; returns 1 time unit after the edge.
  task automatic pair(input logic b1, input logic b2);
    Serial_Bit1 = b1;
    Serial_Bit2 = b2;
    @(posedge RxDDRClkHS);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) pair(b[2*i], b[2*i+1]);
  endtask

  // Four zero pairs of leader, then the given sync byte; returns after edge k.
  task automatic send_leader_sync(input logic [7:0] w);
    for (int i = 0; i < 4; i++) pair(1'b0, 1'b0);
    send_byte(w);
  endtask

  initial begin
    $display("tb_hs_deserializer start");
    pair(0, 0);
    pair(0, 0);
    chk("rst_t_data", t_data, 8'h00);
    chk("rst_t_flags", {3'b0, t_valid, t_active, t_sync, t_errsot, t_errsync}, 8'h00);
    chk("rst_s_flags", {3'b0, s_valid, s_active, s_sync, s_errsot, s_errsync}, 8'h00);

    // Phase-0 sync, bytes 0x33 and 0xC3.
    RxRst = 1'b0;
    Deserializer_Enable = 1'b1;
    send_leader_sync(8'hB8);
    chk("p0_no_early_sync", t_sync, 1'b0);
    pair(1, 1);
    chk("p0_t_sync", t_sync, 1'b1);
    chk("p0_t_errsot", t_errsot, 1'b0);
    chk("p0_t_active", t_active, 1'b1);
    chk("p0_s_sync", s_sync, 1'b1);
    pair(0, 0);
    chk("p0_sync_pulse_end", t_sync, 1'b0);
    pair(1, 1);
    pair(0, 0);
    chk("p0_no_valid_k4", t_valid, 1'b0);
    pair(1, 1);
    chk("p0_valid_k5", t_valid, 1'b1);
    chk("p0_byte0", t_data, 8'h33);
    pair(0, 0);
    chk("p0_valid_drop", t_valid, 1'b0);
    chk("p0_data_hold", t_data, 8'h33);
    pair(0, 0);
    pair(1, 1);
    pair(0, 0);
    chk("p0_valid_k9", t_valid, 1'b1);
    chk("p0_byte1", t_data, 8'hC3);
    chk("p0_s_byte1", s_data, 8'hC3);

    // Phase-1: same stream preceded by one extra zero bit.
    Deserializer_Enable = 1'b0;
    pair(0, 0);
    chk("off_t_active", t_active, 1'b0);
    Deserializer_Enable = 1'b1;
    for (int i = 0; i < 5; i++) pair(0, 0);
    pair(0, 0);
    pair(1, 1);
    pair(1, 0);
    pair(1, 1);
    chk("p1_no_early_sync", t_sync, 1'b0);
    pair(1, 0);
    chk("p1_t_sync", t_sync, 1'b1);
    chk("p1_t_errsot", t_errsot, 1'b0);
    chk("p1_s_sync", s_sync, 1'b1);
    pair(0, 1);
    pair(1, 0);
    pair(0, 1);
    chk("p1_no_valid_k4", t_valid, 1'b0);
    pair(1, 0);
    chk("p1_valid_k5", t_valid, 1'b1);
    chk("p1_byte0", t_data, 8'h33);
    pair(0, 0);
    pair(0, 1);
    pair(1, 0);
    pair(0, 0);
    chk("p1_valid_k9", t_valid, 1'b1);
    chk("p1_byte1", t_data, 8'hC3);

    // Enable dropped two cycles into byte 0xC3.
    Deserializer_Enable = 1'b0;
    pair(0, 0);
    Deserializer_Enable = 1'b1;
    send_leader_sync(8'hB8);
    send_byte(8'h33);
    pair(1, 1);
    chk("ed_byte0", t_data, 8'h33);
    pair(0, 0);
    Deserializer_Enable = 1'b0;
    pair(0, 0);
    chk("ed_t_active", t_active, 1'b0);
    chk("ed_t_valid", t_valid, 1'b0);
    chk("ed_s_active", s_active, 1'b0);
    pair(1, 1);
    chk("ed_t_valid2", t_valid, 1'b0);
    chk("ed_data_hold", t_data, 8'h33);

    // Re-enable: resync, then 0xA5 and 0x5A.
    Deserializer_Enable = 1'b1;
    send_leader_sync(8'hB8);
    pair(1, 0);
    chk("re_t_sync", t_sync, 1'b1);
    chk("re_s_sync", s_sync, 1'b1);
    pair(1, 0);
    pair(0, 1);
    pair(0, 1);
    pair(0, 1);
    chk("re_byte0", t_data, 8'hA5);
    chk("re_valid0", t_valid, 1'b1);
    pair(0, 1);
    pair(1, 0);
    pair(1, 0);
    pair(0, 0);
    chk("re_byte1", t_data, 8'h5A);
    chk("re_s_byte1", s_data, 8'h5A);

    // One-bit-error sync 0xB9: tolerant accepts, strict keeps hunting.
    Deserializer_Enable = 1'b0;
    pair(0, 0);
    Deserializer_Enable = 1'b1;
    send_leader_sync(8'hB9);
    chk("tol_no_early_sync", t_sync, 1'b0);
    pair(1, 1);
    chk("tol_t_sync", t_sync, 1'b1);
    chk("tol_t_errsot", t_errsot, 1'b1);
    chk("tol_s_sync", s_sync, 1'b0);
    chk("tol_s_active", s_active, 1'b0);
    pair(0, 0);
    chk("tol_errsot_pulse_end", t_errsot, 1'b0);
    pair(1, 1);
    pair(0, 0);
    pair(0, 0);
    chk("tol_valid", t_valid, 1'b1);
    chk("tol_byte0", t_data, 8'h33);
    for (int i = 0; i < 7; i++) pair(0, 0);
    chk("to_s_errsync_early", s_errsync, 1'b0);
    for (int i = 0; i < 50; i++) pair(0, 0);
    chk("to_s_errsync", s_errsync, 1'b1);
    chk("to_t_errsync", t_errsync, 1'b0);
    send_leader_sync(8'hB8);
    pair(0, 0);
    chk("to_late_s_sync", s_sync, 1'b1);
    chk("to_late_s_errsot", s_errsot, 1'b0);
    chk("to_errsync_sticky", s_errsync, 1'b1);
    Deserializer_Enable = 1'b0;
    pair(0, 0);
    chk("to_errsync_clear", s_errsync, 1'b0);
    chk("to_s_active_clear", s_active, 1'b0);

    // Reset mid-byte in DATA, then resync.
    Deserializer_Enable = 1'b1;
    send_leader_sync(8'hB8);
    send_byte(8'h33);
    pair(1, 1);
    chk("rd_byte0", t_data, 8'h33);
    pair(0, 0);
    RxRst = 1'b1;
    pair(1, 1);
    chk("rd_t_data", t_data, 8'h00);
    chk("rd_t_flags", {3'b0, t_valid, t_active, t_sync, t_errsot, t_errsync}, 8'h00);
    chk("rd_s_active", s_active, 1'b0);
    RxRst = 1'b0;
    send_leader_sync(8'hB8);
    pair(1, 0);
    chk("rd_resync", t_sync, 1'b1);
    chk("rd_active", t_active, 1'b1);
    pair(1, 0);
    pair(0, 1);
    pair(0, 1);
    pair(0, 0);
    chk("rd_valid", t_valid, 1'b1);
    chk("rd_byte", t_data, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_deserializer.md
Name: hs_deserializer

Overview:
- HS receive-side deserializer for the D-PHY data lane; the receive counterpart of the TX serializer.
- Accepts two serial bits per DDR clock and hunts for the HS sync word at any bit offset.
- After sync, assembles LSB-first bytes and presents them one per 4 DDR cycles on a byte/valid interface for the RX protocol logic.

Parameters:
- SYNC_WORD, 8'hB8, HS leader sync byte (transmitted LSB first: 0,0,0,1,1,1,0,1).
- HUNT_TIMEOUT, 64, DDR cycles in HUNT without sync before ErrSotSyncHS is flagged; must be at least 1.
- SOT_TOLERANT, 1, 1 = accept a sync with a single-bit error (ErrSotHS); 0 = exact match only.

Ports:
- RxDDRClkHS  input  1  DDR bit clock; the only clock; all logic on its rising edge.
- RxRst  input  1  synchronous reset, active-high.
- Deserializer_Enable  input  1  HS receive enable; low = lane not in HS.
- Serial_Bit1  input  1  earlier bit of the current cycle's pair.
- Serial_Bit2  input  1  later bit of the current cycle's pair.
- RxByteHS_Data  output  8  received byte, LSB = first received bit.
- RxValidHS  output  1  one-cycle strobe; RxByteHS_Data valid.
- RxActiveHS  output  1  high while synchronized (DATA state).
- RxSyncHS  output  1  one-cycle pulse on sync detection.
- ErrSotHS  output  1  one-cycle pulse with RxSyncHS when the sync matched with exactly one bit error.
- ErrSotSyncHS  output  1  sticky; sync not found within HUNT_TIMEOUT.

Behaviour:
- Reset (RxRst=1 at an edge): all outputs 0, state IDLE, hist=0, counters 0. Reset overrides everything, including mid-byte.
- hist[9:0] is the bit history: each enabled edge, hist <= {Serial_Bit2, Serial_Bit1, hist[9:2]}. hist[9] is the newest bit.
- While Deserializer_Enable=0, hist is held at 0.
- Windows, evaluated on the registered hist:
  - W0 = hist[9:2], phase 0: byte ends on Bit2.
  - W1 = hist[8:1], phase 1: byte ends on Bit1.
- States:
  - IDLE: if Enable=1, go to HUNT.
  - HUNT: the sync-detection rules below apply; if Enable=0, go to IDLE.
  - DATA: byte capture; if Enable=0, go to IDLE.
- Sync detection in HUNT:
  - Exact match W0==SYNC_WORD wins over an exact match on W1.
  - Any exact match wins over a tolerant match.
  - Tolerant match (SOT_TOLERANT=1): Hamming distance to SYNC_WORD is 1, and the bit preceding the window is 0 (hist[1] for W0, hist[0] for W1). W0 wins over W1.
  - On a match: latch phase, cnt<=0, go to DATA, RxSyncHS=1 for one cycle. ErrSotHS=1 on the same cycle only for a tolerant match.
- Timing: the last sync bit is sampled at edge k. RxSyncHS and RxActiveHS rise after edge k+1.
- DATA:
  - cnt (2-bit) increments each cycle.
  - When the cnt value reaches 3, the next edge registers RxByteHS_Data <= (phase ? W1 : W0) and pulses RxValidHS.
  - Result: the first data byte's last bit is sampled at edge k+4, and RxValidHS is high after edge k+5.
  - Then one byte every 4 cycles. No sync re-detection in DATA.
- RxByteHS_Data holds its last value between strobes.
- Hunt timeout:
  - The hunt counter counts cycles in HUNT and saturates.
  - When it reaches HUNT_TIMEOUT, ErrSotSyncHS is set. The state stays HUNT, and a later sync is still accepted.
- ErrSotSyncHS clears only on reset or Enable=0.
- Enable falling (any state), effective at the next edge:
  - State goes to IDLE and hist clears.
  - RxActiveHS goes 0; the partial byte is discarded with no RxValidHS.
  - The hunt counter and ErrSotSyncHS clear.
- Enable low-to-high restarts hunting from a cleared history.

Test Plan:
- Phase-0 sync: Enable=1; pairs (0,0)x4, sync (0,0),(0,1),(1,1),(0,1), then 0x33 as (1,1),(0,0),(1,1),(0,0), then 0xC3 as (1,1),(0,0),(0,0),(1,1) -> RxSyncHS pulse, ErrSotHS=0; RxValidHS with 0x33 at edge k+5 and 0xC3 at edge k+9; RxActiveHS=1.
- Phase-1 sync: same stream preceded by one extra 0 bit -> sync detected with phase 1; bytes 0x33, 0xC3 recovered at the same 4-cycle cadence.
- Tolerant sync: sync sent as 0xB9, SOT_TOLERANT=1 -> RxSyncHS and ErrSotHS both pulse; data 0x33 received.
- Same stream, SOT_TOLERANT=0 -> no sync; ErrSotSyncHS=1 after 64 cycles.
- Enable drop: Enable=0 two cycles into byte 0xC3 -> no RxValidHS for it; RxActiveHS=0 next cycle.
- Re-enable: Enable back to 1 followed by a leader and sync -> resync, then correct bytes.
- Reset in DATA: RxRst=1 for 1 cycle mid-byte -> all outputs 0 next cycle; state IDLE; hunting resumes once RxRst=0 with Enable=1.
